llsc_mem_unit: RTL

- MEM-stage load/store unit of the MIPS core, sitting between EX and the LLbit register.
- Issues data-bus transactions for LW/LB/LBU/SW/SB/LL/SC and returns write-back results.
- Generates the wbit/wLLbit write pair that the LLbit register consumes, and reads rLLbit back to decide SC success.
- Raises a pipeline stall while a bus access is outstanding.

---
 rtl/llsc_mem_unit_pkg.sv | 45 ++++
 rtl/llsc_mem_unit_mem_align.sv | 49 ++++
 rtl/llsc_mem_unit.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/llsc_mem_unit_pkg.sv
// llsc_mem_unit_pkg
// Shared constants for the MEM-stage load/store unit: op encodings, the
// active-low reset level, valid/zero literals, bus widths, the FSM state type
// and small op-classification helpers.
package llsc_mem_unit_pkg;

  // EX -> MEM op encodings
  localparam logic [2:0] OP_NONE = 3'd0;
  localparam logic [2:0] OP_LW   = 3'd1;
  localparam logic [2:0] OP_LB   = 3'd2;
  localparam logic [2:0] OP_LBU  = 3'd3;
  localparam logic [2:0] OP_SW   = 3'd4;
  localparam logic [2:0] OP_SB   = 3'd5;
  localparam logic [2:0] OP_LL   = 3'd6;
  localparam logic [2:0] OP_SC   = 3'd7;

  // Reset is asserted when the reset pin is low
  localparam logic RST_ENABLE = 1'b0;
  localparam logic VALID      = 1'b1;
  localparam logic ZERO       = 1'b0;

  localparam int DATA_W     = 32;
  localparam int BE_W       = 4;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  function automatic logic is_byte_op(input logic [2:0] op);
    return (op == OP_LB) || (op == OP_LBU) || (op == OP_SB);
  endfunction

  // Word-sized ops that must be 4-byte aligned
  function automatic logic is_word_op(input logic [2:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_LL) || (op == OP_SC);
  endfunction

  function automatic logic is_store(input logic [2:0] op);
    return (op == OP_SW) || (op == OP_SB) || (op == OP_SC);
  endfunction

endpackage

// File: rtl/llsc_mem_unit_mem_align.sv
// mem_align
// Combinational lane logic for the load/store unit.
// Ports:
//   op         in   3   op encoding (see llsc_mem_unit_pkg)
//   addr_lo    in   2   low address bits (byte lane)
//   wdata      in  32   raw store data (rt)
//   rdata      in  32   raw bus read data
//   misaligned out  1   word op with non-zero addr_lo
//   sel        out  4   byte lane enables (little-endian)
//   wdata_rep  out 32   store data, low byte replicated on byte ops
//   rdata_ext  out 32   load data, byte picked and sign/zero extended
module mem_align (
  input  logic [2:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic        misaligned,
  output logic [3:0]  sel,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext
);
  import llsc_mem_unit_pkg::*;

  logic       byte_op;
  logic [7:0] rbyte;

  assign byte_op    = is_byte_op(op);
  assign misaligned = is_word_op(op) && (addr_lo != 2'b00);

  genvar gi;
  generate
    for (gi = 0; gi < BE_W; gi++) begin : g_lane
      assign sel[gi]             = byte_op ? (addr_lo == 2'(gi)) : 1'b1;
      assign wdata_rep[8*gi +: 8] = byte_op ? wdata[7:0] : wdata[8*gi +: 8];
    end
  endgenerate

  assign rbyte = rdata[{addr_lo, 3'b000} +: 8];

  always_comb begin
    rdata_ext = rdata;
    if (op == OP_LB) begin
      rdata_ext = {{24{rbyte[7]}}, rbyte};
    end else if (op == OP_LBU) begin
      rdata_ext = {24'h000000, rbyte};
    end
  end

endmodule

// File: rtl/llsc_mem_unit.sv
// llsc_mem_unit
// MEM-stage load/store unit: issues data-bus transactions for
// LW/LB/LBU/SW/SB/LL/SC, returns write-back results, drives the LLbit
// write pair (wbit/wLLbit) and stalls the pipeline while a bus access is
// outstanding. Reset (rst) is asynchronous, active-low.
// Optional build macro LLSC_SNOOP_EN: adds snoop_valid/snoop_addr; a snooped
// write to the last LL word clears LLbit.
// Ports:
//   clk, rst                       clock, async active-low reset
//   in_valid/in_op/in_addr/in_wdata/in_waddr/in_wreg   EX result
//   excpt                          exception/eret flush
//   rLLbit                         current LLbit
//   dreq/dwe/dsel/daddr/dwdata     data-bus request (held until dack)
//   drdata/dack                    data-bus response
//   stall_req                      freeze upstream stages
//   out_valid/out_we/out_waddr/out_wdata   write-back result
//   wbit/wLLbit                    LLbit write strobe / value
//   addr_err/bus_err               misalignment / timeout pulses
//   snoop_valid/snoop_addr         (LLSC_SNOOP_EN only)
module llsc_mem_unit
  import llsc_mem_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int ADDR_W         = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [2:0]            in_op,
  input  logic [ADDR_W-1:0]     in_addr,
  input  logic [DATA_W-1:0]     in_wdata,
  input  logic [REG_ADDR_W-1:0] in_waddr,
  input  logic                  in_wreg,
  input  logic                  excpt,
  input  logic                  rLLbit,
  output logic                  dreq,
  output logic                  dwe,
  output logic [BE_W-1:0]       dsel,
  output logic [ADDR_W-1:0]     daddr,
  output logic [DATA_W-1:0]     dwdata,
  input  logic [DATA_W-1:0]     drdata,
  input  logic                  dack,
`ifdef LLSC_SNOOP_EN
  input  logic                  snoop_valid,
  input  logic [ADDR_W-1:0]     snoop_addr,
`endif
  output logic                  stall_req,
  output logic                  out_valid,
  output logic                  out_we,
  output logic [REG_ADDR_W-1:0] out_waddr,
  output logic [DATA_W-1:0]     out_wdata,
  output logic                  wbit,
  output logic                  wLLbit,
  output logic                  addr_err,
  output logic                  bus_err
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t                  state_reg;
  logic [CNT_W-1:0]        cnt_reg;
  logic                    discard_reg;
  logic [2:0]              op_reg;
  logic [1:0]              addr_lo_reg;
  logic                    wreg_reg;
  logic [REG_ADDR_W-1:0]   waddr_reg;

  logic [2:0]              align_op;
  logic [1:0]              align_lo;
  logic                    misaligned;
  logic [BE_W-1:0]         sel;
  logic [DATA_W-1:0]       wdata_rep;
  logic [DATA_W-1:0]       rdata_ext;
  logic                    accept;
  logic                    snoop_hit;

  // One aligner serves both directions: in IDLE it shapes the incoming
  // request, in ACCESS it extends the returning read data for the held op.
  assign align_op = (state_reg == ST_IDLE) ? in_op : op_reg;
  assign align_lo = (state_reg == ST_IDLE) ? in_addr[1:0] : addr_lo_reg;

  mem_align u_align (
    .op         (align_op),
    .addr_lo    (align_lo),
    .wdata      (in_wdata),
    .rdata      (drdata),
    .misaligned (misaligned),
    .sel        (sel),
    .wdata_rep  (wdata_rep),
    .rdata_ext  (rdata_ext)
  );

  // A bus access starts this cycle
  assign accept = (state_reg == ST_IDLE) && in_valid && !excpt &&
                  (in_op != OP_NONE) && !misaligned &&
                  !((in_op == OP_SC) && !rLLbit);

  // Combinational so the upstream stages freeze in the accept cycle itself
  assign stall_req = accept || (state_reg == ST_ACCESS);

`ifdef LLSC_SNOOP_EN
  logic [ADDR_W-3:0] ll_addr_reg;
  logic              ll_done;

  assign ll_done   = (state_reg == ST_ACCESS) && dack && !discard_reg &&
                     !excpt && (op_reg == OP_LL);
  assign snoop_hit = snoop_valid && rLLbit &&
                     (snoop_addr[ADDR_W-1:2] == ll_addr_reg);

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      ll_addr_reg <= '0;
    end else if (ll_done) begin
      ll_addr_reg <= daddr[ADDR_W-1:2];
    end
  end
`else
  assign snoop_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      discard_reg <= 1'b0;
      op_reg      <= OP_NONE;
      addr_lo_reg <= 2'b00;
      wreg_reg    <= 1'b0;
      waddr_reg   <= '0;
      dreq        <= ZERO;
      dwe         <= ZERO;
      dsel        <= '0;
      daddr       <= '0;
      dwdata      <= '0;
      out_valid   <= ZERO;
      out_we      <= ZERO;
      out_waddr   <= '0;
      out_wdata   <= '0;
      wbit        <= ZERO;
      wLLbit      <= ZERO;
      addr_err    <= ZERO;
      bus_err     <= ZERO;
    end else begin
      // Pulses default low; a snoop clear is the lowest-priority LLbit write
      out_valid <= ZERO;
      out_we    <= ZERO;
      addr_err  <= ZERO;
      bus_err   <= ZERO;
      wbit      <= snoop_hit;
      wLLbit    <= ZERO;

      case (state_reg)
        ST_IDLE: begin
          if (in_valid && !excpt) begin
            if (in_op == OP_NONE) begin
              out_valid <= VALID;
              out_we    <= in_wreg;
              out_waddr <= in_waddr;
              out_wdata <= in_wdata;
            end else if (misaligned) begin
              addr_err <= VALID;
            end else if ((in_op == OP_SC) && !rLLbit) begin
              // Reservation already lost: fail without touching the bus
              out_valid <= VALID;
              out_we    <= in_wreg;
              out_waddr <= in_waddr;
              out_wdata <= '0;
              wbit      <= VALID;
              wLLbit    <= ZERO;
            end else begin
              op_reg      <= in_op;
              addr_lo_reg <= in_addr[1:0];
              wreg_reg    <= in_wreg;
              waddr_reg   <= in_waddr;
              dreq        <= VALID;
              dwe         <= is_store(in_op);
              dsel        <= sel;
              daddr       <= {in_addr[ADDR_W-1:2], 2'b00};
              dwdata      <= wdata_rep;
              cnt_reg     <= '0;
              discard_reg <= 1'b0;
              state_reg   <= ST_ACCESS;
            end
          end
        end

        ST_ACCESS: begin
          // A flush cannot retract the bus cycle; remember to drop its result
          if (excpt) begin
            discard_reg <= 1'b1;
          end
          // dack is tested first so it wins over a same-cycle timeout
          if (dack) begin
            dreq <= ZERO;
            dwe  <= ZERO;
            dsel <= '0;
            if (discard_reg || excpt) begin
              state_reg <= ST_IDLE;
            end else begin
              state_reg <= ST_RESP;
              out_valid <= VALID;
              out_waddr <= waddr_reg;
              case (op_reg)
                OP_SW, OP_SB: begin
                  out_we <= ZERO;
                end
                OP_SC: begin
                  out_we    <= wreg_reg;
                  out_wdata <= 32'd1;
                  wbit      <= VALID;
                  wLLbit    <= ZERO;
                end
                OP_LL: begin
                  out_we    <= wreg_reg;
                  out_wdata <= rdata_ext;
                  wbit      <= VALID;
                  wLLbit    <= VALID;
                end
                default: begin
                  out_we    <= wreg_reg;
                  out_wdata <= rdata_ext;
                end
              endcase
            end
          end else if (cnt_reg == CNT_LAST) begin
            bus_err   <= VALID;
            dreq      <= ZERO;
            dwe       <= ZERO;
            dsel      <= '0;
            state_reg <= ST_IDLE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end

        ST_RESP: begin
          state_reg <= ST_IDLE;
        end

        default: begin
          state_reg <= ST_IDLE;
        end
      endcase

      // Flush overrides every other LLbit write and any result
      if (excpt) begin
        wbit      <= VALID;
        wLLbit    <= ZERO;
        out_valid <= ZERO;
      end
    end
  end

endmodule
